stream_decoder: RTL and testbench

//  Registered, handshaked successor to the combinational binary-to-one-hot decoder.

---
 rtl/stream_decoder.sv | 115 +++++++++++
 tb/tb_stream_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_decoder.sv
// Registered, valid/ready-handshaked code decoder. It produces a one-hot or thermometer
// pattern, or a bubble-free sweep of one-hot beats running from a start code up to max.
module stream_decoder #(
  parameter int ENCODE_WIDTH = 4,
  // Derived from ENCODE_WIDTH; it is not meant to be overridden.
  parameter int DECODE_WIDTH = 2 ** ENCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ENCODE_WIDTH-1:0] in_code,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DECODE_WIDTH-1:0] out_data,
  output logic [ENCODE_WIDTH-1:0] out_code,
  output logic                    out_last,
  output logic                    out_err,
  output logic                    busy
);

  typedef enum logic [1:0] {
    MODE_ONEHOT  = 2'b00,
    MODE_THERMO  = 2'b01,
    MODE_SWEEP   = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic [ENCODE_WIDTH-1:0] MAX_CODE = {ENCODE_WIDTH{1'b1}};

  state_e                  state;
  logic                    in_fire;
  logic                    out_fire;
  logic [ENCODE_WIDTH-1:0] next_code;

  function automatic logic [DECODE_WIDTH-1:0] onehot(input logic [ENCODE_WIDTH-1:0] c);
    logic [DECODE_WIDTH-1:0] p;
    p    = '0;
    p[c] = 1'b1;
    return p;
  endfunction

  function automatic logic [DECODE_WIDTH-1:0] thermo(input logic [ENCODE_WIDTH-1:0] c);
    logic [DECODE_WIDTH-1:0] p;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      p[k] = (k <= int'(c));
    end
    return p;
  endfunction

  // A new command can enter in the same cycle that the pending beat drains.
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign next_code = out_code + ENCODE_WIDTH'(1);

  // NOTE: every register here is written with non-blocking assignments, so all of them
  // see the values from before the clock edge. Otherwise a next-state decision could
  // observe a value that was already updated earlier in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_code  <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_code  <= in_code;
      out_err   <= 1'b0;
      out_last  <= 1'b1;
      case (mode_e'(in_mode))
        MODE_ONEHOT: out_data <= onehot(in_code);
        MODE_THERMO: out_data <= thermo(in_code);
        MODE_SWEEP: begin
          out_data <= onehot(in_code);
          // A sweep that starts at max is a single terminal beat and stays in IDLE.
          if (in_code != MAX_CODE) begin
            out_last <= 1'b0;
            state    <= SWEEP;
            busy     <= 1'b1;
          end
        end
        default: begin
          out_data <= '0;
          out_err  <= 1'b1;
        end
      endcase
    end else if (state == SWEEP) begin
      if (out_fire) begin
        if (out_last) begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end else begin
          out_code <= next_code;
          out_data <= onehot(next_code);
          out_last <= (next_code == MAX_CODE);
        end
      end
    end else if (out_fire) begin
      // Data and code keep their last values once the beat is consumed.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_decoder.sv
// Self-checking bench for stream_decoder (ENCODE_WIDTH=4): directed scenarios plus random
// traffic, checked against a queue of expected beats derived from the decode rules.
module tb_stream_decoder;

  localparam int EW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_code;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_code;
  logic          out_last;
  logic          out_err;
  logic          busy;

  stream_decoder #(.ENCODE_WIDTH(EW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_code (out_code),
    .out_last (out_last),
    .out_err  (out_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [EW-1:0] code;
    logic          last;
    logic          err;
    logic          sweep;
  } beat_t;

  beat_t q[$];
  bit    rdy_pat[$];
  bit    rdy_rand = 1'b0;
  int    tests_run = 0;
  int    tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats of one accepted command, built straight from the mode rules.
  task automatic push_cmd(input logic [1:0] mode, input logic [EW-1:0] code);
    logic [DW:0] wide;
    beat_t b;
    case (mode)
      2'b00: q.push_back('{data: DW'(1) << code, code: code, last: 1'b1, err: 1'b0, sweep: 1'b0});
      2'b01: begin
        wide = ((DW+1)'(1) << (int'(code) + 1)) - (DW+1)'(1);
        q.push_back('{data: wide[DW-1:0], code: code, last: 1'b1, err: 1'b0, sweep: 1'b0});
      end
      2'b10: begin
        for (int c = int'(code); c < DW; c++) begin
          b.data  = DW'(1) << c;
          b.code  = EW'(c);
          b.last  = (c == DW - 1);
          b.err   = 1'b0;
          b.sweep = (int'(code) != DW - 1);
          q.push_back(b);
        end
      end
      default: q.push_back('{data: '0, code: code, last: 1'b1, err: 1'b1, sweep: 1'b0});
    endcase
  endtask

  // Scoreboard: compares outputs with the head of the queue every cycle, then applies
  // the transfers that happen on the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0) begin
        check("out_valid", 32'(out_valid), 32'd1);
        if (out_valid) begin
          check("out_data", 32'(out_data), 32'(q[0].data));
          check("out_code", 32'(out_code), 32'(q[0].code));
          check("out_last", 32'(out_last), 32'(q[0].last));
          check("out_err",  32'(out_err),  32'(q[0].err));
          check("busy",     32'(busy),     32'(q[0].sweep));
          check("in_ready", 32'(in_ready), 32'(!q[0].sweep && out_ready));
        end
      end else begin
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_busy",      32'(busy),      32'd0);
        check("idle_in_ready",  32'(in_ready),  32'd1);
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) push_cmd(in_mode, in_code);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
    else if (rdy_rand)      out_ready = ($urandom_range(0, 3) != 0);
    else                    out_ready = 1'b1;
  end

  // Holds one command until it is accepted; returns the number of cycles it waited.
  task automatic send(input logic [1:0] mode, input logic [EW-1:0] code, output int waits);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_code  = code;
    waits    = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data),  32'd0);
    check({tag, "_code"},  32'(out_code),  32'd0);
    check({tag, "_last"},  32'(out_last),  32'd0);
    check({tag, "_err"},   32'(out_err),   32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    int w;
    int total_waits;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    #3;
    check_reset_outputs("rst");
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-hot codes 0..15 back to back: each one accepted without waiting.
    total_waits = 0;
    for (int i = 0; i < DW; i++) begin
      send(2'b00, EW'(i), w);
      total_waits += w;
    end
    check("onehot_b2b_waits", 32'(total_waits), 32'd0);
    drain();

    // Thermometer: 0 -> 0x0001, 7 -> 0x00FF, 15 -> 0xFFFF.
    send(2'b01, 4'd0, w);
    send(2'b01, 4'd7, w);
    send(2'b01, 4'd15, w);
    drain();

    // Sweep from 12 with ready held high, then from 13 with stalls.
    send(2'b10, 4'd12, w);
    drain();
    rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    send(2'b10, 4'd13, w);
    drain();
    send(2'b10, 4'd15, w);
    drain();

    // Illegal mode, followed by a normal beat with err clear.
    send(2'b11, 4'd5, w);
    send(2'b00, 4'd3, w);
    drain();

    // Reset while the second beat of a sweep from 10 is on the output.
    send(2'b10, 4'd10, w);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    q.delete();
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;

    // Random traffic with random backpressure and idle gaps.
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(2'($urandom_range(0, 3)), EW'($urandom_range(0, DW - 1)), w);
    end
    drain();
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
